note_step_sequencer: RTL and testbench
======================================

Name: note_step_sequencer

Overview:
Plays a programmable pattern of 4-bit note codes, one step per tempo period, driving the note input of the note-to-interval decoder that feeds the square-wave generator. Holds an internal pattern memory written by the control logic (buttons/UART), and supports start/stop, looping, configurable pattern length and a fixed rest gap at the end of each step for note articulation.

Parameters:
NUM_STEPS, 8, pattern length capacity (2..16); index width SW = $clog2(NUM_STEPS)
GAP_TICKS, 24'd600000, clk cycles of forced rest at the end of every step (0 = legato)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin playback from step 0
stop  in  1  one-cycle pulse: halt playback
loop_en  in  1  1 = wrap to step 0 after last step; 0 = stop after last step
last_step  in  SW  index of final step in pattern
step_ticks  in  24  step length in clk cycles, sampled at each step start
wr_en  in  1  pattern write strobe
wr_addr  in  SW  pattern write address
wr_note  in  4  note code to store
note  out  4  current note code to decoder (4'b1111 = rest)
step_idx  out  SW  index of step being played
step_pulse  out  1  one-cycle pulse on the first cycle of each step
playing  out  1  high while in NOTE or GAP
done  out  1  one-cycle pulse when a non-looping pattern finishes

Behaviour:
- Reset (async, immediate): state IDLE, note=4'b1111, step_idx=0, step_pulse=0, playing=0, done=0, tick counter=0, all pattern entries=4'b1111.
- States: IDLE, NOTE, GAP. All outputs registered.
- Effective step length L = max(step_ticks, GAP_TICKS+1), latched with the note at step start; mid-step changes to step_ticks do not affect the current step.
- Step start (cycle after start accepted, or cycle after previous step ends): counter=0, note=mem[step_idx], step_pulse=1, state NOTE, playing=1.
- NOTE: counter increments each cycle; when counter == L-GAP_TICKS-1, go to GAP next cycle with note=4'b1111. If GAP_TICKS=0, GAP is skipped.
- GAP (or NOTE when GAP_TICKS=0): when counter == L-1, step ends. Step spans exactly L cycles; note is valid for L-GAP_TICKS cycles.
- End of step: if step_idx < last_step, step_idx+1 and new step start. If step_idx == last_step: loop_en=1 -> step_idx=0 and new step start; loop_en=0 -> IDLE, note=rest, playing=0, step_idx=0, done=1 for one cycle.
- last_step >= NUM_STEPS is treated as NUM_STEPS-1. wr_addr >= NUM_STEPS writes are ignored.
- stop: from any state, next cycle IDLE, note=rest, step_idx=0, playing=0, no done pulse.
- start in NOTE/GAP: restart from step 0 (new step start next cycle).
- start and stop in the same cycle: stop wins.
- Writes are accepted in any state and take effect in one cycle. The note latched at step start holds for the whole step. A write to the address being latched in the same cycle gives the old value to the current step and the new value on the next visit.
- loop_en and last_step are sampled only at end of step.

Decomposition:
- seq_pkg: note code constants (C4=0000, D4=0001, E4=0011, F4=1000, G4=0110, A4=0101, B4=0010, C5=0111, REST=1111), seq_state_t enum {IDLE, NOTE, GAP}.
- Sub-module seq_pattern_mem: NUM_STEPS x 4-bit register file, async reset to REST, one write port and one combinational read port.

Test Plan:
- Reset then idle 50 cycles -> note=1111, playing=0, step_idx=0, no step_pulse.
- GAP_TICKS=2, step_ticks=10, pattern [0000,0001,0011], last_step=2, loop_en=0, start -> each step 10 cycles (note 8 cycles, then rest 2 cycles), step_pulse at cycles 1/11/21, done at end of cycle 30, then IDLE.
- Same setup with loop_en=1 -> after step 2, step_idx=0 and note=0000 with step_pulse; continues for 3 full loops.
- stop asserted mid-NOTE of step 1 -> next cycle note=1111, playing=0, step_idx=0, done stays 0; start and stop in the same cycle -> stays IDLE.
- step_ticks=1 with GAP_TICKS=2 -> L=3: note 1 cycle, rest 2 cycles. step_ticks changed mid-step -> current step length unchanged.
- Write 0101 to step 1 while step 1 is playing 0001 -> note stays 0001 this step and is 0101 on the next loop. Async rst asserted mid-GAP -> outputs reset immediately and pattern clears to 1111.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared note codes, sequencer state encoding and step-length helper
// for the note step sequencer.
package seq_pkg;

    localparam logic [3:0] NOTE_C4   = 4'b0000;
    localparam logic [3:0] NOTE_D4   = 4'b0001;
    localparam logic [3:0] NOTE_E4   = 4'b0011;
    localparam logic [3:0] NOTE_F4   = 4'b1000;
    localparam logic [3:0] NOTE_G4   = 4'b0110;
    localparam logic [3:0] NOTE_A4   = 4'b0101;
    localparam logic [3:0] NOTE_B4   = 4'b0010;
    localparam logic [3:0] NOTE_C5   = 4'b0111;
    localparam logic [3:0] NOTE_REST = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    // A step must be long enough to hold the whole rest gap plus one note cycle.
    function automatic logic [23:0] eff_step_len(input logic [23:0] ticks,
                                                 input logic [23:0] gap);
        logic [23:0] len;
        if (ticks > gap) begin
            len = ticks;
        end else begin
            len = gap + 24'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_pattern_mem.sv
// Pattern register file: NUM_STEPS x 4-bit notes, cleared to rest on reset,
// one synchronous write port and one combinational read port.
import seq_pkg::*;

module seq_pattern_mem #(
    parameter int NUM_STEPS = 8,
    localparam int SW = $clog2(NUM_STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic [SW-1:0] rd_addr,
    output logic [3:0]    rd_data
);

    logic [3:0] mem_q [NUM_STEPS];

    // Out-of-range write addresses match no entry and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem_q[i] <= NOTE_REST;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                if (wr_addr == SW'(i)) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/note_step_sequencer.sv
// Step sequencer: plays stored note codes one step per tempo period with a
// fixed trailing rest gap, supporting start/stop, looping and variable length.
import seq_pkg::*;

module note_step_sequencer #(
    parameter int          NUM_STEPS = 8,
    parameter logic [23:0] GAP_TICKS = 24'd600000,
    localparam int         SW        = $clog2(NUM_STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [SW-1:0] last_step,
    input  logic [23:0]   step_ticks,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
    input  logic [3:0]    wr_note,
    output logic [3:0]    note,
    output logic [SW-1:0] step_idx,
    output logic          step_pulse,
    output logic          playing,
    output logic          done
);

    localparam bit GAP_ZERO = (GAP_TICKS == 24'd0);

    seq_state_t    state_q, state_d;
    logic [3:0]    note_q, note_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [23:0]   cnt_q, cnt_d;
    logic [23:0]   len_q, len_d;
    logic          pulse_q, pulse_d;
    logic          playing_q, playing_d;
    logic          done_q, done_d;

    logic [SW-1:0] last_eff_s;
    logic [SW-1:0] launch_idx_s;
    logic [3:0]    rd_note_s;
    logic [23:0]   last_cnt_s;
    logic [23:0]   note_end_s;
    logic          step_end_s;
    logic          launch_s;

    generate
        if ((1 << SW) == NUM_STEPS) begin : g_last_full
            assign last_eff_s = last_step;
        end else begin : g_last_clamp
            localparam logic [SW-1:0] LAST_IDX = SW'(NUM_STEPS - 1);
            assign last_eff_s = (last_step > LAST_IDX) ? LAST_IDX : last_step;
        end
    endgenerate

    seq_pattern_mem #(
        .NUM_STEPS(NUM_STEPS)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_note),
        .rd_addr (launch_idx_s),
        .rd_data (rd_note_s)
    );

    assign last_cnt_s = len_q - 24'd1;
    assign note_end_s = len_q - GAP_TICKS - 24'd1;
    assign step_end_s = (((state_q == NOTE) && GAP_ZERO) || (state_q == GAP))
                        && (cnt_q == last_cnt_s);

    // Index of the step that would start next; a start pulse always rewinds.
    always_comb begin
        if (start) begin
            launch_idx_s = '0;
        end else if (idx_q < last_eff_s) begin
            launch_idx_s = idx_q + SW'(1);
        end else begin
            launch_idx_s = '0;
        end
    end

    // Next-state logic: stop beats start, start beats normal step progress.
    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        playing_d = playing_q;
        pulse_d   = 1'b0;
        done_d    = 1'b0;
        launch_s  = 1'b0;

        if (stop) begin
            state_d   = IDLE;
            note_d    = NOTE_REST;
            idx_d     = '0;
            cnt_d     = 24'd0;
            playing_d = 1'b0;
        end else if (start) begin
            launch_s = 1'b1;
        end else if (step_end_s) begin
            if ((idx_q < last_eff_s) || loop_en) begin
                launch_s = 1'b1;
            end else begin
                state_d   = IDLE;
                note_d    = NOTE_REST;
                idx_d     = '0;
                cnt_d     = 24'd0;
                playing_d = 1'b0;
                done_d    = 1'b1;
            end
        end else if ((state_q == NOTE) && (cnt_q == note_end_s)) begin
            state_d = GAP;
            note_d  = NOTE_REST;
            cnt_d   = cnt_q + 24'd1;
        end else if (state_q != IDLE) begin
            cnt_d = cnt_q + 24'd1;
        end else begin
            cnt_d = cnt_q;
        end

        // The memory read reflects the pre-write contents, so a same-cycle write
        // to this address only shows up on the next visit.
        if (launch_s) begin
            state_d   = NOTE;
            note_d    = rd_note_s;
            idx_d     = launch_idx_s;
            cnt_d     = 24'd0;
            len_d     = eff_step_len(step_ticks, GAP_TICKS);
            playing_d = 1'b1;
            pulse_d   = 1'b1;
        end else begin
            len_d = len_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            note_q    <= NOTE_REST;
            idx_q     <= '0;
            cnt_q     <= 24'd0;
            len_q     <= 24'd0;
            pulse_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            pulse_q   <= pulse_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign note       = note_q;
    assign step_idx   = idx_q;
    assign step_pulse = pulse_q;
    assign playing    = playing_q;
    assign done       = done_q;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Scoreboard bench for note_step_sequencer: a timeline model predicts every
// output cycle, expectations are queued and compared after each clock edge.
module tb_note_step_sequencer;

    localparam int          NSTEPS = 8;
    localparam logic [23:0] GAP    = 24'd2;

    typedef struct packed {
        logic [3:0] note;
        logic [2:0] idx;
        logic       pulse;
        logic       playing;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [2:0]  last_step = 3'd0;
    logic [23:0] step_ticks = 24'd10;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [3:0]  wr_note = 4'd0;
    logic [3:0]  note;
    logic [2:0]  step_idx;
    logic        step_pulse;
    logic        playing;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;

    exp_t exp_q[$];

    // timeline model state
    bit          m_active;
    logic [2:0]  m_idx;
    logic [23:0] m_pos;
    logic [23:0] m_len;
    logic [3:0]  m_lnote;
    logic [3:0]  m_mem [NSTEPS];

    note_step_sequencer #(
        .NUM_STEPS(NSTEPS),
        .GAP_TICKS(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_step  (last_step),
        .step_ticks (step_ticks),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .note       (note),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .playing    (playing),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_idx    = 3'd0;
        m_pos    = 24'd0;
        m_len    = 24'd0;
        m_lnote  = 4'hF;
        for (int i = 0; i < NSTEPS; i++) m_mem[i] = 4'hF;
    endtask

    // Predicts the outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        exp_t       e;
        bit         launch;
        logic [2:0] nidx;
        bit         pulse;
        bit         dn;
        launch = 1'b0;
        nidx   = 3'd0;
        pulse  = 1'b0;
        dn     = 1'b0;
        if (stop) begin
            m_active = 1'b0;
            m_idx    = 3'd0;
        end else if (start) begin
            launch = 1'b1;
            nidx   = 3'd0;
        end else if (m_active) begin
            if (m_pos == m_len - 24'd1) begin
                if (m_idx < last_step) begin
                    launch = 1'b1;
                    nidx   = 3'(m_idx + 3'd1);
                end else if (loop_en) begin
                    launch = 1'b1;
                    nidx   = 3'd0;
                end else begin
                    m_active = 1'b0;
                    m_idx    = 3'd0;
                    dn       = 1'b1;
                end
            end else begin
                m_pos = m_pos + 24'd1;
            end
        end
        if (launch) begin
            m_active = 1'b1;
            m_idx    = nidx;
            m_pos    = 24'd0;
            m_len    = (step_ticks > GAP) ? step_ticks : GAP + 24'd1;
            m_lnote  = m_mem[nidx];
            pulse    = 1'b1;
        end
        if (wr_en) m_mem[wr_addr] = wr_note;
        e.note    = (m_active && (m_pos < m_len - GAP)) ? m_lnote : 4'hF;
        e.idx     = m_idx;
        e.pulse   = pulse;
        e.playing = m_active;
        e.done    = dn;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("note",       32'(note),       32'(e.note));
            check_val("step_idx",   32'(step_idx),   32'(e.idx));
            check_val("step_pulse", 32'(step_pulse), 32'(e.pulse));
            check_val("playing",    32'(playing),    32'(e.playing));
            check_val("done",       32'(done),       32'(e.done));
        end
        if (step_pulse) pulse_cnt++;
        if (done) done_cnt++;
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_pat(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = d;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_note"},    32'(note),       32'hF);
        check_val({tag, "_idx"},     32'(step_idx),   32'd0);
        check_val({tag, "_pulse"},   32'(step_pulse), 32'd0);
        check_val({tag, "_playing"}, 32'(playing),    32'd0);
        check_val({tag, "_done"},    32'(done),       32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        rst = 1'b0;
        pulse_cnt = 0;
        run(50);
        check_val("idle_pulses", 32'(pulse_cnt), 32'd0);

        // three-step pattern, no loop
        write_pat(3'd0, 4'b0000);
        write_pat(3'd1, 4'b0001);
        write_pat(3'd2, 4'b0011);
        last_step  = 3'd2;
        loop_en    = 1'b0;
        step_ticks = 24'd10;
        pulse_cnt  = 0;
        done_cnt   = 0;
        start      = 1'b1;
        run(35);
        check_val("oneshot_pulses", 32'(pulse_cnt), 32'd3);
        check_val("oneshot_done",   32'(done_cnt),  32'd1);

        // looping for three full passes
        loop_en   = 1'b1;
        pulse_cnt = 0;
        done_cnt  = 0;
        start     = 1'b1;
        run(90);
        check_val("loop_pulses", 32'(pulse_cnt), 32'd9);
        check_val("loop_done",   32'(done_cnt),  32'd0);

        // stop during the note of step 1, then start+stop together from idle
        start = 1'b1;
        run(13);
        stop = 1'b1;
        tick();
        check_reset_outputs("stop");
        start = 1'b1;
        stop  = 1'b1;
        done_cnt = 0;
        run(6);
        check_val("startstop_playing", 32'(playing), 32'd0);
        check_val("stop_no_done", 32'(done_cnt), 32'd0);

        // minimum step length, then step_ticks changed mid-step
        step_ticks = 24'd1;
        start = 1'b1;
        run(10);
        step_ticks = 24'd10;
        start = 1'b1;
        run(3);
        step_ticks = 24'd5;
        run(30);

        // rewrite step 1 while it plays; then write the entry being latched
        step_ticks = 24'd10;
        start = 1'b1;
        run(12);
        write_pat(3'd1, 4'b0101);
        run(40);
        stop = 1'b1;
        tick();
        start = 1'b1;
        run(10);
        write_pat(3'd1, 4'b0110);
        run(30);

        // async reset in the middle of a gap clears outputs and pattern
        start = 1'b1;
        run(9);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_gap");
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        start = 1'b1;
        run(30);
        check_val("cleared_note", 32'(note), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
